// File: rtl/crc16_pkg.sv
// Shared constants for the CRC16 engine arbiter: data widths, engine init value
// and the arbiter FSM state encoding.
package crc16_pkg;

  localparam int BYTE_W  = 8;
  localparam int CRC_W   = 16;
  localparam int STATE_W = 3;

  localparam logic [CRC_W-1:0] CRC16_INIT = 16'hFFFF;

  localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] S_WAIT   = 3'd1;
  localparam logic [STATE_W-1:0] S_INIT   = 3'd2;
  localparam logic [STATE_W-1:0] S_STREAM = 3'd3;
  localparam logic [STATE_W-1:0] S_FIN    = 3'd4;
  localparam logic [STATE_W-1:0] S_DONE   = 3'd5;
  localparam logic [STATE_W-1:0] S_ABORT  = 3'd6;

endpackage

// File: rtl/crc16_arb_wdog.sv
// Seal watchdog: counts enabled cycles since the last clear and flags the
// cycle on which the count reaches TIMEOUT. TIMEOUT = 0 disables it.
module crc16_arb_wdog #(
  parameter int TIMEOUT = 256,
  parameter int TMO_W   = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_d;
  logic             at_limit;

  assign at_limit = (cnt_q == TMO_W'(TIMEOUT - 1));
  assign expire_o = (TIMEOUT != 0) && en_i && at_limit;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !at_limit) begin
      cnt_d = cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/crc16_engine_arbiter.sv
// Shares one crc16_engine between the CPU MMIO path (default owner, combinational
// pass-through) and the seal unit (exclusive ownership sequenced by an FSM).
module crc16_engine_arbiter
  import crc16_pkg::*;
#(
  parameter int SEAL_TIMEOUT = 256,
  parameter int TMO_W        = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_init,
  input  logic [BYTE_W-1:0]  cpu_data,
  input  logic               cpu_data_valid,
  output logic [CRC_W-1:0]   cpu_crc,
  output logic               cpu_busy,
  output logic               cpu_ctx_lost,
  input  logic               seal_req,
  input  logic [BYTE_W-1:0]  seal_data,
  input  logic               seal_valid,
  input  logic               seal_last,
  output logic               seal_ready,
  output logic               seal_gnt,
  output logic [CRC_W-1:0]   seal_crc,
  output logic               seal_done,
  output logic               seal_err,
  output logic               eng_init,
  output logic [BYTE_W-1:0]  eng_data,
  output logic               eng_data_valid,
  input  logic [CRC_W-1:0]   eng_crc,
  input  logic               eng_busy,
  output logic [STATE_W-1:0] dbg_state_o
);

  // Seal handshake: a byte moves when seal_valid & seal_ready are both high on a
  // rising clk edge. seal_ready never depends on seal_valid, and an unaccepted
  // byte must be held stable by the seal unit until it is taken.

  logic [STATE_W-1:0] state_q, state_d;
  logic               guard_q, guard_d;
  logic [CRC_W-1:0]   shadow_q, shadow_d;
  logic               seal_dv_q, seal_dv_d;
  logic [BYTE_W-1:0]  seal_data_q, seal_data_d;
  logic [CRC_W-1:0]   seal_crc_q, seal_crc_d;
  logic               seal_done_q, seal_done_d;
  logic               seal_err_q, seal_err_d;
  logic               ctx_lost_q, ctx_lost_d;

  logic is_idle;
  logic eng_free;
  logic hs;
  logic wd_en;
  logic wd_clr;
  logic wd_expire;

  assign is_idle  = (state_q == S_IDLE);
  // guard bridges the cycle between a data pulse and the engine raising busy
  assign eng_free = !eng_busy && !guard_q;

  assign seal_ready = (state_q == S_STREAM) && eng_free;
  assign hs         = seal_valid && seal_ready;

  assign wd_en  = (state_q == S_STREAM) && !seal_valid;
  assign wd_clr = (state_q != S_STREAM) || hs;

  crc16_arb_wdog #(
    .TIMEOUT (SEAL_TIMEOUT),
    .TMO_W   (TMO_W)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expire_o (wd_expire)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (seal_req) state_d = S_WAIT;
      S_WAIT: begin
        if (!seal_req)     state_d = S_IDLE;
        else if (eng_free) state_d = S_INIT;
      end
      S_INIT:   state_d = S_STREAM;
      S_STREAM: begin
        if (!seal_req || wd_expire) state_d = S_ABORT;
        else if (hs && seal_last)   state_d = S_FIN;
      end
      S_FIN:    if (eng_free) state_d = S_DONE;
      S_DONE:   if (!seal_req) state_d = S_IDLE;
      S_ABORT:  if (eng_free) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // CPU bytes issued in IDLE also arm the guard so S_WAIT cannot init too early.
  assign guard_d     = hs || (is_idle && cpu_data_valid);
  assign shadow_d    = (is_idle && seal_req) ? eng_crc : shadow_q;
  assign seal_dv_d   = hs;
  assign seal_data_d = hs ? seal_data : seal_data_q;
  assign seal_done_d = (state_q == S_FIN) && eng_free;
  assign seal_crc_d  = seal_done_d ? eng_crc : seal_crc_q;
  assign seal_err_d  = wd_expire;

  always_comb begin
    ctx_lost_d = ctx_lost_q;
    if (state_q == S_INIT)        ctx_lost_d = 1'b1;
    else if (is_idle && cpu_init) ctx_lost_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      guard_q     <= 1'b0;
      shadow_q    <= CRC16_INIT;
      seal_dv_q   <= 1'b0;
      seal_data_q <= '0;
      seal_crc_q  <= '0;
      seal_done_q <= 1'b0;
      seal_err_q  <= 1'b0;
      ctx_lost_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      guard_q     <= guard_d;
      shadow_q    <= shadow_d;
      seal_dv_q   <= seal_dv_d;
      seal_data_q <= seal_data_d;
      seal_crc_q  <= seal_crc_d;
      seal_done_q <= seal_done_d;
      seal_err_q  <= seal_err_d;
      ctx_lost_q  <= ctx_lost_d;
    end
  end

  assign eng_init       = is_idle ? cpu_init       : (state_q == S_INIT);
  assign eng_data       = is_idle ? cpu_data       : seal_data_q;
  assign eng_data_valid = is_idle ? cpu_data_valid : seal_dv_q;

  assign cpu_crc      = is_idle ? eng_crc  : shadow_q;
  assign cpu_busy     = is_idle ? eng_busy : 1'b1;
  assign cpu_ctx_lost = ctx_lost_q;

  assign seal_gnt  = (state_q == S_INIT) || (state_q == S_STREAM) ||
                     (state_q == S_FIN)  || (state_q == S_DONE);
  assign seal_crc  = seal_crc_q;
  assign seal_done = seal_done_q;
  assign seal_err  = seal_err_q;

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_crc16_engine_arbiter.sv
// Bench for crc16_engine_arbiter: CRC-16/CCITT-FALSE engine model with random
// 1..3 cycle busy, directed scenarios with randomized payloads and gaps.
module tb_crc16_engine_arbiter;

  localparam int SEAL_TIMEOUT = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_init, cpu_data_valid;
  logic [7:0]  cpu_data;
  logic [15:0] cpu_crc;
  logic        cpu_busy, cpu_ctx_lost;
  logic        seal_req, seal_valid, seal_last;
  logic [7:0]  seal_data;
  logic        seal_ready, seal_gnt, seal_done, seal_err;
  logic [15:0] seal_crc;
  logic        eng_init, eng_data_valid, eng_busy;
  logic [7:0]  eng_data;
  logic [15:0] eng_crc;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  crc16_engine_arbiter #(
    .SEAL_TIMEOUT (SEAL_TIMEOUT),
    .TMO_W        (9)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_init       (cpu_init),
    .cpu_data       (cpu_data),
    .cpu_data_valid (cpu_data_valid),
    .cpu_crc        (cpu_crc),
    .cpu_busy       (cpu_busy),
    .cpu_ctx_lost   (cpu_ctx_lost),
    .seal_req       (seal_req),
    .seal_data      (seal_data),
    .seal_valid     (seal_valid),
    .seal_last      (seal_last),
    .seal_ready     (seal_ready),
    .seal_gnt       (seal_gnt),
    .seal_crc       (seal_crc),
    .seal_done      (seal_done),
    .seal_err       (seal_err),
    .eng_init       (eng_init),
    .eng_data       (eng_data),
    .eng_data_valid (eng_data_valid),
    .eng_crc        (eng_crc),
    .eng_busy       (eng_busy),
    .dbg_state_o    (dbg_state)
  );

  // ---------------- reference CRC and engine model ----------------
  function automatic logic [15:0] crc_ref(input logic [7:0] m[$]);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (m[i]) begin
      for (int k = 7; k >= 0; k--) begin
        fb = c[15] ^ m[i][k];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  function automatic logic [15:0] eng_step(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  logic [15:0] e_crc = 16'hFFFF;
  int          e_cnt = 0;
  assign eng_crc  = e_crc;
  assign eng_busy = (e_cnt != 0);

  always @(posedge clk) begin
    if (eng_data_valid) begin
      e_crc <= eng_step(e_crc, eng_data);
      e_cnt <= int'($urandom_range(3, 1));
    end else begin
      if (eng_init) e_crc <= 16'hFFFF;
      if (e_cnt > 0) e_cnt <= e_cnt - 1;
    end
  end

  // ---------------- event monitors ----------------
  int          n_init = 0, n_dv = 0, n_done = 0, n_err = 0, n_gnt = 0;
  int          n_initbusy = 0, frz_bad = 0;
  bit          frz_on = 1'b0;
  logic [15:0] frz_exp = 16'h0000;

  always @(posedge clk) begin
    if (!rst) begin
      if (eng_init)       n_init <= n_init + 1;
      if (eng_data_valid) n_dv   <= n_dv + 1;
      if (seal_done)      n_done <= n_done + 1;
      if (seal_err)       n_err  <= n_err + 1;
      if (seal_gnt)       n_gnt  <= n_gnt + 1;
      if (seal_gnt && eng_init && eng_busy) n_initbusy <= n_initbusy + 1;
      if (frz_on && (cpu_busy !== 1'b1 || cpu_crc !== frz_exp)) frz_bad <= frz_bad + 1;
    end
  end

  // ---------------- scoreboard bookkeeping ----------------
  int         n_cmp = 0, n_bad = 0, tmo_cnt = 0;
  int         b_init, b_dv, b_done, b_err, b_gnt;
  logic [7:0] msg_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic snap();
    b_init = n_init; b_dv = n_dv; b_done = n_done; b_err = n_err; b_gnt = n_gnt;
  endtask

  task automatic rand_msg(input int len);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
  endtask

  // ---------------- driver tasks (all called at a negedge) ----------------
  task automatic cpu_wait_free();
    int n;
    n = 0;
    while (cpu_busy && n < 50) begin @(negedge clk); n++; end
    if (cpu_busy) tmo_cnt++;
  endtask

  task automatic cpu_pulse_init();
    cpu_wait_free();
    cpu_init = 1'b1;
    @(negedge clk);
    cpu_init = 1'b0;
  endtask

  task automatic cpu_byte(input logic [7:0] b);
    cpu_wait_free();
    cpu_data = b; cpu_data_valid = 1'b1;
    @(negedge clk);
    cpu_data_valid = 1'b0;
  endtask

  task automatic drive_noise(input bit noise);
    cpu_data       = 8'($urandom);
    cpu_data_valid = noise ? 1'($urandom_range(1, 0)) : 1'b0;
    cpu_init       = noise ? ($urandom_range(7, 0) == 0) : 1'b0;
  endtask

  task automatic seal_stream(input int nb, input bit with_last, input int max_gap, input bit noise);
    int   g, w;
    logic r;
    for (int i = 0; i < nb; i++) begin
      g = int'($urandom_range(max_gap, 0));
      for (int k = 0; k < g; k++) begin drive_noise(noise); @(negedge clk); end
      seal_valid = 1'b1; seal_data = msg_q[i];
      seal_last  = with_last && (i == nb - 1);
      w = 0;
      forever begin
        drive_noise(noise);
        #1 r = seal_ready;
        @(negedge clk);
        if (r) break;
        w++;
        if (w > 40) begin tmo_cnt++; break; end
      end
      seal_valid = 1'b0; seal_last = 1'b0;
    end
    drive_noise(1'b0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!seal_done && n < 60) begin @(negedge clk); n++; end
    if (!seal_done) tmo_cnt++;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((seal_gnt || cpu_busy) && n < 60) begin @(negedge clk); n++; end
    if (seal_gnt || cpu_busy) tmo_cnt++;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1, "global timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [15:0] prev_crc;
    int          n, len;

    rst = 1'b1; cpu_init = 1'b0; cpu_data = 8'h00; cpu_data_valid = 1'b0;
    seal_req = 1'b0; seal_data = 8'h00; seal_valid = 1'b0; seal_last = 1'b0;

    // reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_seal_crc",  32'(seal_crc), 32'h0);
    chk("rst_seal_gnt",  32'(seal_gnt), 32'h0);
    chk("rst_seal_done", 32'(seal_done), 32'h0);
    chk("rst_seal_err",  32'(seal_err), 32'h0);
    chk("rst_ctx_lost",  32'(cpu_ctx_lost), 32'h0);
    chk("rst_seal_rdy",  32'(seal_ready), 32'h0);
    chk("rst_cpu_busy",  32'(cpu_busy), 32'h0);
    chk("rst_state",     32'(dbg_state), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // CPU computes "123456789" alone
    snap();
    msg_q.delete();
    for (int i = 0; i < 9; i++) msg_q.push_back(8'(8'h31 + i));
    cpu_pulse_init();
    foreach (msg_q[i]) cpu_byte(msg_q[i]);
    cpu_wait_free();
    chk("cpu_check_const", 32'(cpu_crc), 32'h29B1);
    chk("cpu_check_ref",   32'(cpu_crc), 32'(crc_ref(msg_q)));
    chk("cpu_ctx_clean",   32'(cpu_ctx_lost), 32'h0);
    chk("cpu_no_gnt",      32'(n_gnt - b_gnt), 32'h0);

    // seal computes "123456789"
    snap();
    seal_req = 1'b1;
    @(negedge clk);
    seal_stream(9, 1'b1, 3, 1'b0);
    wait_done();
    chk("seal_check_const", 32'(seal_crc), 32'h29B1);
    chk("seal_gnt_done",    32'(seal_gnt), 32'h1);
    chk("seal_ctx_set",     32'(cpu_ctx_lost), 32'h1);
    chk("seal_cpu_busy",    32'(cpu_busy), 32'h1);
    seal_req = 1'b0;
    wait_idle();
    @(negedge clk);
    chk("seal_init_once", 32'(n_init - b_init), 32'd1);
    chk("seal_dv_count",  32'(n_dv - b_dv), 32'd9);
    chk("seal_done_1cyc", 32'(n_done - b_done), 32'd1);
    chk("seal_no_err",    32'(n_err - b_err), 32'd0);
    chk("seal_release",   32'(dbg_state), 32'h0);
    cpu_pulse_init();
    chk("ctx_cleared", 32'(cpu_ctx_lost), 32'h0);

    // random seal messages
    for (int t = 0; t < 4; t++) begin
      len = int'($urandom_range(12, 1));
      rand_msg(len);
      snap();
      seal_req = 1'b1;
      @(negedge clk);
      seal_stream(len, 1'b1, 3, 1'b0);
      wait_done();
      chk("rand_seal_crc", 32'(seal_crc), 32'(crc_ref(msg_q)));
      seal_req = 1'b0;
      wait_idle();
      chk("rand_seal_dv", 32'(n_dv - b_dv), 32'(len));
    end

    // CPU mid-CRC interrupted by seal; CPU writes during seal must be dropped
    cpu_pulse_init();
    msg_q.delete();
    for (int i = 0; i < 4; i++) msg_q.push_back(8'(8'h31 + i));
    foreach (msg_q[i]) cpu_byte(msg_q[i]);
    cpu_wait_free();
    frz_exp = crc_ref(msg_q);
    chk("mid_cpu_partial", 32'(cpu_crc), 32'(frz_exp));
    seal_req = 1'b1;
    @(negedge clk);
    chk("mid_cpu_busy",   32'(cpu_busy), 32'h1);
    chk("mid_cpu_shadow", 32'(cpu_crc), 32'(frz_exp));
    frz_on = 1'b1;
    rand_msg(6);
    snap();
    seal_stream(6, 1'b1, 2, 1'b1);
    wait_done();
    frz_on = 1'b0;
    chk("mid_frozen",   32'(frz_bad), 32'd0);
    chk("mid_seal_crc", 32'(seal_crc), 32'(crc_ref(msg_q)));
    chk("mid_dropped",  32'(n_dv - b_dv), 32'd6);
    seal_req = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("mid_ctx_sticky", 32'(cpu_ctx_lost), 32'h1);
    cpu_pulse_init();
    chk("mid_ctx_clear", 32'(cpu_ctx_lost), 32'h0);

    // seal_req in the same cycle as a CPU byte
    cpu_wait_free();
    snap();
    seal_req = 1'b1; cpu_data = 8'hA5; cpu_data_valid = 1'b1;
    #1;
    chk("same_eng_dv",   32'(eng_data_valid), 32'h1);
    chk("same_eng_data", 32'(eng_data), 32'hA5);
    @(negedge clk);
    cpu_data_valid = 1'b0;
    chk("same_wait_gnt",  32'(seal_gnt), 32'h0);
    chk("same_wait_busy", 32'(cpu_busy), 32'h1);
    rand_msg(5);
    seal_stream(5, 1'b1, 3, 1'b0);
    wait_done();
    chk("same_seal_crc",  32'(seal_crc), 32'(crc_ref(msg_q)));
    chk("same_init_idle", 32'(n_initbusy), 32'd0);
    chk("same_init_once", 32'(n_init - b_init), 32'd1);
    chk("same_dv_count",  32'(n_dv - b_dv), 32'd6);
    seal_req = 1'b0;
    wait_idle();

    // watchdog: seal stalls after two bytes
    prev_crc = seal_crc;
    snap();
    seal_req = 1'b1;
    @(negedge clk);
    rand_msg(2);
    seal_stream(2, 1'b0, 1, 1'b0);
    n = 0;
    while (n < 400) begin
      @(posedge clk);
      n++;
      #1;
      if (seal_err) break;
    end
    chk("wdog_cycles", 32'(n), 32'(SEAL_TIMEOUT));
    @(negedge clk);
    seal_req = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    chk("wdog_err_pulse", 32'(n_err - b_err), 32'd1);
    chk("wdog_no_done",   32'(n_done - b_done), 32'd0);
    chk("wdog_crc_kept",  32'(seal_crc), 32'(prev_crc));
    chk("wdog_idle",      32'(dbg_state), 32'h0);

    // seal_req dropped after three bytes
    prev_crc = seal_crc;
    snap();
    seal_req = 1'b1;
    @(negedge clk);
    rand_msg(3);
    seal_stream(3, 1'b0, 2, 1'b0);
    seal_req = 1'b0;
    wait_idle();
    @(negedge clk);
    chk("abort_no_done",  32'(n_done - b_done), 32'd0);
    chk("abort_no_err",   32'(n_err - b_err), 32'd0);
    chk("abort_dv",       32'(n_dv - b_dv), 32'd3);
    chk("abort_crc_kept", 32'(seal_crc), 32'(prev_crc));
    chk("abort_gnt",      32'(seal_gnt), 32'h0);

    // asynchronous reset mid-stream
    seal_req = 1'b1;
    @(negedge clk);
    rand_msg(2);
    seal_stream(2, 1'b0, 1, 1'b0);
    chk("mrst_pre_ctx", 32'(cpu_ctx_lost), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("mrst_seal_crc", 32'(seal_crc), 32'h0);
    chk("mrst_gnt",      32'(seal_gnt), 32'h0);
    chk("mrst_ready",    32'(seal_ready), 32'h0);
    chk("mrst_ctx",      32'(cpu_ctx_lost), 32'h0);
    chk("mrst_state",    32'(dbg_state), 32'h0);
    chk("mrst_eng_dv",   32'(eng_data_valid), 32'h0);
    chk("mrst_eng_init", 32'(eng_init), 32'h0);
    chk("mrst_cpu_busy", 32'(cpu_busy), 32'(eng_busy));
    seal_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mrst_stay_idle", 32'(dbg_state), 32'h0);

    chk("no_wait_timeouts", 32'(tmo_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
